// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-master / three-slave arbiter and address decoder for the CPU memory bus.
// Master 0 is the CPU, master 1 the DMA engine. A granted transaction is
// registered onto the shared slave bus, routed to one slave by address, and its
// read data and completion are returned to the owning master. A watchdog
// aborts an access whose slave never answers.
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   m0_* / m1_*                     master request side (req/rw/addr/wdata/size in,
//                                   rdata/done/err out, done is a 1-cycle pulse)
//   s_addr/s_rw/s_wdata/s_size      registered transaction to all slaves
//   s_req[2:0]                      one-hot slave select {periph, sdram, mem}
//   s_rdata[95:0], s_rec[2:0]       slave read data and data-valid, same order
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter logic [31:0] MEM_LIMIT = 32'h0002FFFF,
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] ERR_DATA  = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_rw,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [1:0]  m0_size,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_rw,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_size,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic [31:0] s_addr,
    output logic        s_rw,
    output logic [31:0] s_wdata,
    output logic [1:0]  s_size,
    output logic [2:0]  s_req,
    input  logic [95:0] s_rdata,
    input  logic [2:0]  s_rec
);

    localparam int             CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Address map: bit31 set -> peripherals, below MEM_LIMIT -> on-chip memory,
    // everything else -> SDRAM.
    function automatic logic [2:0] decode(input logic [31:0] addr);
        logic [2:0] sel;
        if (addr[31]) begin
            sel = 3'b100;
        end else if (addr < MEM_LIMIT) begin
            sel = 3'b001;
        end else begin
            sel = 3'b010;
        end
        return sel;
    endfunction

    state_t         state_r;
    logic           last_grant_r;   // also identifies the owner while busy
    logic [2:0]     sel_r;          // selected slave, kept through RELEASE
    logic [CW-1:0]  cnt_r;

    logic           grant_s;
    logic [31:0]    g_addr_s;
    logic           g_rw_s;
    logic [31:0]    g_wdata_s;
    logic [1:0]     g_size_s;
    logic [2:0]     g_sel_s;
    logic           rec_sel_s;
    logic [31:0]    rdata_sel_s;
    logic           cmpl_s;
    logic [31:0]    cmpl_data_s;
    logic           cmpl_err_s;

    // Round-robin pick and mux of the winning master's transaction fields.
    always_comb begin
        if (m0_req && m1_req) begin
            grant_s = ~last_grant_r;
        end else if (m1_req) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            g_addr_s  = m1_addr;
            g_rw_s    = m1_rw;
            g_wdata_s = m1_wdata;
            g_size_s  = m1_size;
        end else begin
            g_addr_s  = m0_addr;
            g_rw_s    = m0_rw;
            g_wdata_s = m0_wdata;
            g_size_s  = m0_size;
        end
        g_sel_s = decode(g_addr_s);
    end

    // Only the selected slave's rec and data slice are ever looked at.
    always_comb begin
        rec_sel_s = |(s_rec & sel_r);
        case (sel_r)
            3'b001:  rdata_sel_s = s_rdata[31:0];
            3'b010:  rdata_sel_s = s_rdata[63:32];
            3'b100:  rdata_sel_s = s_rdata[95:64];
            default: rdata_sel_s = 32'h00000000;
        endcase
    end

    // Completion condition in ACCESS: slave answer wins over a same-cycle timeout.
    always_comb begin
        if (state_r == ACCESS) begin
            cmpl_s = rec_sel_s || (cnt_r == CNT_LAST);
        end else begin
            cmpl_s = 1'b0;
        end
        if (rec_sel_s) begin
            cmpl_data_s = rdata_sel_s;
            cmpl_err_s  = 1'b0;
        end else begin
            cmpl_data_s = ERR_DATA;
            cmpl_err_s  = 1'b1;
        end
    end

    // Arbitration FSM with all bus and master outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            sel_r        <= 3'b000;
            cnt_r        <= '0;
            s_addr       <= 32'h00000000;
            s_rw         <= 1'b0;
            s_wdata      <= 32'h00000000;
            s_size       <= 2'b00;
            s_req        <= 3'b000;
            m0_rdata     <= 32'h00000000;
            m0_done      <= 1'b0;
            m0_err       <= 1'b0;
            m1_rdata     <= 32'h00000000;
            m1_done      <= 1'b0;
            m1_err       <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m0_err  <= 1'b0;
            m1_done <= 1'b0;
            m1_err  <= 1'b0;

            if (cmpl_s) begin
                if (last_grant_r) begin
                    m1_rdata <= cmpl_data_s;
                    m1_done  <= 1'b1;
                    m1_err   <= cmpl_err_s;
                end else begin
                    m0_rdata <= cmpl_data_s;
                    m0_done  <= 1'b1;
                    m0_err   <= cmpl_err_s;
                end
            end

            case (state_r)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        s_addr       <= g_addr_s;
                        s_rw         <= g_rw_s;
                        s_wdata      <= g_wdata_s;
                        s_size       <= g_size_s;
                        s_req        <= g_sel_s;
                        sel_r        <= g_sel_s;
                        last_grant_r <= grant_s;
                        cnt_r        <= '0;
                        state_r      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cmpl_s) begin
                        s_req   <= 3'b000;
                        state_r <= RELEASE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RELEASE: begin
                    // A long rec must fall before the bus is offered again.
                    if (!rec_sel_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    s_req   <= 3'b000;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, three-slave arbiter and address decoder for the CPU memory bus.
- Shares the bus between master 0 (CPU) and master 1 (DMA engine).
- Routes each granted transaction to the on-chip memory controller, the SDRAM controller or the peripheral block, and returns read data and completion to the owning master.
- Adds a bus timeout so a hung slave cannot stall a master indefinitely.

Parameters:
MEM_LIMIT, 32'h0002FFFF, addresses with addr[31]=0 and addr < MEM_LIMIT decode to slave 0 (on-chip memory)
TIMEOUT, 1024, cycles in ACCESS without slave rec before abort; counter width is clog2(TIMEOUT)+1
ERR_DATA, 32'h00000000, m*_rdata value returned on timeout

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low
m0_req  in  1  master 0 request; level, held with m0_addr/rw/wdata/size stable until m0_done
m0_rw  in  1  1 = write, 0 = read
m0_addr  in  32  byte address
m0_wdata  in  32  write data
m0_size  in  2  access size, passed through unchanged
m0_rdata  out  32  read data, valid in the m0_done cycle
m0_done  out  1  one-cycle completion pulse
m0_err  out  1  high with m0_done when the access timed out
m1_req, m1_rw, m1_addr, m1_wdata, m1_size, m1_rdata, m1_done, m1_err  as m0_*, for master 1
s_addr  out  32  registered address to all slaves
s_rw  out  1  registered rw to all slaves
s_wdata  out  32  registered write data
s_size  out  2  registered size
s_req  out  3  one-hot request: bit0 memory, bit1 sdram, bit2 peripherals
s_rdata  in  96  slave read data, {periph, sdram, mem}
s_rec  in  3  slave data_valid / rec, same bit order as s_req

Behaviour:
- Reset low: state IDLE, every output 0, last_grant = 1, so master 0 wins the first tie. Reset mid-transaction drops s_req immediately and the transaction is lost.
- States: IDLE, ACCESS, RELEASE.
- IDLE:
  - If any mX_req is high, grant one master. If both are requesting, grant the master that is not last_grant (round-robin).
  - On the grant edge: latch that master's addr/rw/wdata/size into s_*, update last_grant, set the decoded s_req bit, clear the timeout counter, and go to ACCESS.
  - s_req is visible 1 cycle after mX_req is sampled.
- Decode rules: addr[31]=1 selects bit2; otherwise addr < MEM_LIMIT selects bit0; otherwise bit1. Exactly one s_req bit is high in ACCESS; all are 0 in IDLE and RELEASE.
- ACCESS, selected s_rec high at edge M:
  - Capture the selected 32-bit s_rdata slice into the granted mX_rdata.
  - Pulse mX_done for the single cycle following M with mX_err=0.
  - Clear s_req and go to RELEASE.
- ACCESS with the timeout counter reaching TIMEOUT-1 and no rec: mX_rdata=ERR_DATA, mX_done=1 and mX_err=1 for one cycle, clear s_req, go to RELEASE.
- s_rec bits of unselected slaves are ignored at all times.
- RELEASE: wait until the selected s_rec bit is low, then go to IDLE. This prevents a multi-cycle rec from completing the next transaction. Minimum back-to-back spacing is therefore mX_done, then RELEASE, then IDLE grant.
- mX_rdata holds its value until the next completion for that master. The non-granted master's done/err stay 0.
- A master dropping req during ACCESS does not abort the transaction; it still completes and pulses done. A master must not deassert req before done.
- s_addr/s_rw/s_wdata/s_size hold their last values in IDLE and RELEASE.

Test Plan:
- Reset release, m0 read at 0x00000100, s_rec[0] high 3 cycles after s_req[0] -> s_req=3'b001 one cycle after req; m0_done single pulse with m0_rdata = s_rdata[31:0]; state back to IDLE after rec falls.
- m1 write at 0x00030000, then at 0x80000004 -> s_req=3'b010 then 3'b100; s_rw=1 and s_wdata match; m0_done never pulses.
- m0 and m1 requesting continuously -> grants alternate m0, m1, m0, m1 after reset; no master is granted twice in a row while the other waits.
- Slave holds s_rec[1] high 5 cycles -> exactly one m_done; next grant only after s_rec[1] falls.
- No s_rec with TIMEOUT=16 -> done and err pulse 16 cycles after s_req rises; rdata=ERR_DATA; a subsequent request completes normally.
- Reset asserted in ACCESS -> s_req=0 and all done/err=0 asynchronously; after release, m0 wins the first tie.
